cmult_axil_slave: RTL and testbench

CMULT_AXIL_SLAVE -- requirements
Module: cmult_axil_slave

---
 rtl/cmult_axil_slave.sv | 118 +++++++++++
 tb/tb_cmult_axil_slave.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmult_axil_slave.sv
// cmult_axil_slave: AXI4-Lite register block driving a Q1.15 complex multiplier
// with a programmable-latency IDLE/CALC sequencer and a done interrupt pulse.
module cmult_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int MULT_LATENCY       = 3
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            done_irq
);
   typedef enum logic {IDLE, CALC} state_t;
   localparam logic [3:0] LAT = 4'(MULT_LATENCY);
   state_t state;
   logic [31:0] opa, opb, result, op_a, op_b, rd_mux;
   logic [3:0] cnt;
   logic done, aw_rdy, wr_en, rd_en, start, clr, unused;
   logic [1:0] wsel, rsel;
   logic signed [15:0] ar, ai, br, bi;
   logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [32:0] re_f, im_f;

   function automatic logic [15:0] sat(input logic signed [17:0] s);
      return s > 18'sd32767 ? 16'h7FFF : s < -18'sd32768 ? 16'h8000 : s[15:0];
   endfunction

   assign S_AXI_AWREADY = aw_rdy;
   assign S_AXI_WREADY  = aw_rdy;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_RRESP   = 2'b00;
   assign wsel  = S_AXI_AWADDR[3:2];
   assign rsel  = S_AXI_ARADDR[3:2];
   assign wr_en = aw_rdy & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_en = S_AXI_ARREADY & S_AXI_ARVALID;
   assign start = wr_en & (wsel == 2'd2) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
   assign clr   = wr_en & (wsel == 2'd2) & S_AXI_WSTRB[0] & S_AXI_WDATA[2];
   assign {ai, ar} = op_a;
   assign {bi, br} = op_b;
   assign p_rr = ar * br;
   assign p_ii = ai * bi;
   assign p_ri = ar * bi;
   assign p_ir = ai * br;
   assign re_f = p_rr - p_ii;
   assign im_f = p_ri + p_ir;
   assign rd_mux = rsel == 2'd0 ? opa : rsel == 2'd1 ? opb :
                   rsel == 2'd2 ? {29'd0, done, state == CALC, 1'b0} : result;
   assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                     re_f[14:0], im_f[14:0]};

   always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) begin
         aw_rdy        <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
      end else begin
         aw_rdy        <= ~aw_rdy & S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID;
         S_AXI_BVALID  <= wr_en | (S_AXI_BVALID & ~S_AXI_BREADY);
         S_AXI_ARREADY <= ~S_AXI_ARREADY & S_AXI_ARVALID & ~S_AXI_RVALID;
         S_AXI_RVALID  <= rd_en | (S_AXI_RVALID & ~S_AXI_RREADY);
         if (rd_en) S_AXI_RDATA <= rd_mux;
      end

   always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) begin
         state    <= IDLE;
         opa      <= '0;
         opb      <= '0;
         op_a     <= '0;
         op_b     <= '0;
         result   <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         done_irq <= 1'b0;
      end else begin
         done_irq <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (wr_en && wsel == 2'd0 && S_AXI_WSTRB[i]) opa[8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            if (wr_en && wsel == 2'd1 && S_AXI_WSTRB[i]) opb[8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
         end
         // the running multiply works from snapshots, so OPA/OPB stay writable during CALC
         if (state == IDLE) begin
            if (start) begin
               op_a  <= opa;
               op_b  <= opb;
               cnt   <= LAT;
               done  <= 1'b0;
               state <= CALC;
            end else if (clr) done <= 1'b0;
         end else if (cnt == 4'd1) begin
            result   <= {sat(im_f[32:15]), sat(re_f[32:15])};
            cnt      <= '0;
            done     <= 1'b1;
            done_irq <= 1'b1;
            state    <= IDLE;
         end else cnt <= cnt - 4'd1;
      end
endmodule

// File: tb/tb_cmult_axil_slave.sv
// tb_cmult_axil_slave: scenario tasks drive AXI-Lite traffic; a read monitor
// pops expected values from a scoreboard queue as read data returns.
module tb_cmult_axil_slave;
   logic clk = 1'b0, rst;
   logic [3:0] S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WSTRB;
   logic [2:0] S_AXI_AWPROT, S_AXI_ARPROT;
   logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
   logic S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
   logic S_AXI_RVALID, S_AXI_RREADY, done_irq;
   logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
   logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
   int n_checks = 0, n_fail = 0, irq_cnt = 0;
   logic [31:0] exp_q[$];
   string nm_q[$];
   logic [31:0] e_mon;
   string nm_mon;

   always #5 clk = ~clk;

   cmult_axil_slave dut (
      .ACLK(clk), .ARESET(rst),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .done_irq(done_irq)
   );

   always @(negedge clk) if (done_irq) irq_cnt++;

   always @(negedge clk)
      if (S_AXI_RVALID && S_AXI_RREADY) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rvalid got %h", S_AXI_RDATA);
         end else begin
            e_mon = exp_q.pop_front();
            nm_mon = nm_q.pop_front();
            if ({S_AXI_RRESP, S_AXI_RDATA} !== {2'b00, e_mon}) begin
               n_fail++;
               $display("FAIL %s got resp=%b data=%h expected resp=00 data=%h", nm_mon, S_AXI_RRESP, S_AXI_RDATA, e_mon);
            end
         end
      end

   function automatic logic [15:0] sat16(input longint x);
      return x > 32767 ? 16'h7FFF : x < -32768 ? 16'h8000 : 16'(x);
   endfunction

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
      longint ar, ai, br, bi, re, im;
      ar = $signed(a[15:0]); ai = $signed(a[31:16]);
      br = $signed(b[15:0]); bi = $signed(b[31:16]);
      re = (ar * br - ai * bi) >>> 15;
      im = (ar * bi + ai * br) >>> 15;
      return {sat16(im), sat16(re)};
   endfunction

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int i;
      @(negedge clk);
      S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      for (i = 0; i < 50 && !S_AXI_AWREADY; i++) @(negedge clk);
      n_checks++;
      if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL write_accept addr=%h got awready=%b wready=%b expected 1", a, S_AXI_AWREADY, S_AXI_WREADY);
      end
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (S_AXI_BVALID) break;
      end
      n_checks++;
      if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b100) begin
         n_fail++;
         $display("FAIL write_resp addr=%h got bvalid=%b bresp=%b expected 1/00", a, S_AXI_BVALID, S_AXI_BRESP);
      end
   endtask

   task automatic axi_read(input logic [3:0] a, input logic [31:0] e, input string nm);
      int i;
      exp_q.push_back(e);
      nm_q.push_back(nm);
      @(negedge clk);
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
      for (i = 0; i < 50 && !S_AXI_ARREADY; i++) @(negedge clk);
      @(posedge clk); #1;
      S_AXI_ARVALID = 1'b0;
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (S_AXI_RVALID) break;
      end
      if (!S_AXI_RVALID) begin
         n_checks++; n_fail++;
         $display("FAIL %s read timeout got rvalid=0 expected 1", nm);
         void'(exp_q.pop_front());
         void'(nm_q.pop_front());
      end
   endtask

   task automatic wait_irq();
      for (int i = 0; i < 30 && !done_irq; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
           S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, done_irq} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got aw=%b w=%b b=%b ar=%b r=%b rdata=%h irq=%b expected all 0",
                  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, done_irq);
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      rst = 1'b0;
      axi_read(4'h0, 32'h0, "reset_opa");
      axi_read(4'h4, 32'h0, "reset_opb");
      axi_read(4'h8, 32'h0, "reset_status");
      axi_read(4'hC, 32'h0, "reset_result");
   endtask

   task automatic test_mult();
      int irq0;
      axi_write(4'h0, 32'h0000_4000, 4'hF);
      axi_write(4'h4, 32'h0000_4000, 4'hF);
      irq0 = irq_cnt;
      axi_write(4'h8, 32'h1, 4'hF);
      for (int i = 2; i <= 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (done_irq !== (i == 4)) begin
            n_fail++;
            $display("FAIL mult_latency cycle=%0d got irq=%b expected %b", i, done_irq, i == 4);
         end
      end
      axi_read(4'hC, 32'h0000_2000, "mult_result");
      axi_read(4'h8, 32'h4, "mult_status_done");
      n_checks++;
      if (irq_cnt - irq0 !== 1) begin
         n_fail++;
         $display("FAIL mult_irq_count got %0d expected 1", irq_cnt - irq0);
      end
   endtask

   task automatic test_status();
      axi_write(4'h8, 32'h4, 4'hF);
      axi_read(4'h8, 32'h0, "done_clear");
      axi_write(4'h8, 32'h1, 4'hF);
      axi_read(4'h8, 32'h2, "busy_status");
      axi_read(4'h8, 32'h4, "done_sticky");
      axi_write(4'h8, 32'h5, 4'hF);
      axi_read(4'h8, 32'h2, "start_wins_clear");
      wait_irq();
      axi_read(4'h8, 32'h4, "start_clear_done");
   endtask

   task automatic test_arith();
      logic [31:0] a, b;
      logic [31:0] va[6], vb[6], ve[6];
      va[0] = 32'h0000_8000; vb[0] = 32'h0000_8000; ve[0] = 32'h0000_7FFF;
      va[1] = 32'h4000_0000; vb[1] = 32'h4000_0000; ve[1] = 32'h0000_E000;
      va[2] = 32'h8000_8000; vb[2] = 32'h8000_8000; ve[2] = 32'h7FFF_0000;
      va[3] = 32'h0000_FFFF; vb[3] = 32'h0000_0001; ve[3] = 32'h0000_FFFF;
      a = $urandom; b = $urandom;
      va[4] = a; vb[4] = b; ve[4] = model(a, b);
      va[5] = 32'h2000_C000; vb[5] = 32'hE000_6000; ve[5] = model(va[5], vb[5]);
      for (int k = 0; k < 6; k++) begin
         axi_write(4'h0, va[k], 4'hF);
         axi_write(4'h4, vb[k], 4'hF);
         axi_write(4'h8, 32'h1, 4'hF);
         wait_irq();
         axi_read(4'hC, ve[k], $sformatf("arith_%0d", k));
      end
      axi_write(4'hC, 32'h1234_5678, 4'hF);
      axi_read(4'hC, ve[5], "result_readonly");
   endtask

   task automatic test_strobe();
      axi_write(4'h0, 32'h0, 4'hF);
      axi_write(4'h0, 32'hFFFF_FFFF, 4'h1);
      axi_read(4'h0, 32'h0000_00FF, "strobe_byte0");
      axi_write(4'h4, 32'h0, 4'hF);
      axi_write(4'h4, 32'hAABB_CCDD, 4'hC);
      axi_read(4'h7, 32'hAABB_0000, "strobe_upper");
   endtask

   task automatic test_same_reg();
      fork
         axi_write(4'h4, 32'h5555_AAAA, 4'hF);
         axi_read(4'h4, 32'hAABB_0000, "rw_same_old");
      join
      axi_read(4'h4, 32'h5555_AAAA, "rw_same_new");
   endtask

   task automatic test_start_in_calc();
      int irq0;
      axi_write(4'h0, 32'h0000_4000, 4'hF);
      axi_write(4'h4, 32'h0000_4000, 4'hF);
      irq0 = irq_cnt;
      axi_write(4'h8, 32'h1, 4'hF);
      axi_write(4'h8, 32'h1, 4'hF);
      repeat (10) @(negedge clk);
      n_checks++;
      if (irq_cnt - irq0 !== 1) begin
         n_fail++;
         $display("FAIL start_in_calc irq count got %0d expected 1", irq_cnt - irq0);
      end
      axi_read(4'hC, 32'h0000_2000, "start_in_calc_result");
   endtask

   task automatic test_back_to_back();
      int i;
      S_AXI_BREADY = 1'b0;
      @(negedge clk);
      S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h1111_1111; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      for (i = 0; i < 50 && !S_AXI_AWREADY; i++) @(negedge clk);
      @(posedge clk); #1;
      S_AXI_WDATA = 32'h2222_2222;
      for (i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100) begin
            n_fail++;
            $display("FAIL bready_hold cycle=%0d got bvalid=%b awready=%b wready=%b expected 1/0/0",
                     i, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
         end
      end
      S_AXI_BREADY = 1'b1;
      for (i = 0; i < 50 && !S_AXI_AWREADY; i++) @(negedge clk);
      n_checks++;
      if (S_AXI_AWREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL queued_write_accept got awready=%b expected 1", S_AXI_AWREADY);
      end
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      @(negedge clk);
      n_checks++;
      if (S_AXI_BVALID !== 1'b1) begin
         n_fail++;
         $display("FAIL queued_write_resp got bvalid=%b expected 1", S_AXI_BVALID);
      end
      axi_read(4'h0, 32'h2222_2222, "queued_write_data");
   endtask

   task automatic test_reset_calc();
      int irq0;
      axi_write(4'h0, 32'h0000_4000, 4'hF);
      axi_write(4'h4, 32'h0000_4000, 4'hF);
      irq0 = irq_cnt;
      axi_write(4'h8, 32'h1, 4'hF);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      n_checks++;
      if (irq_cnt !== irq0) begin
         n_fail++;
         $display("FAIL reset_calc_irq got %0d pulses expected 0", irq_cnt - irq0);
      end
      axi_read(4'h8, 32'h0, "reset_calc_status");
      axi_read(4'hC, 32'h0, "reset_calc_result");
      axi_read(4'h0, 32'h0, "reset_calc_opa");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
      S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      test_reset();
      test_mult();
      test_status();
      test_arith();
      test_strobe();
      test_same_reg();
      test_start_in_calc();
      test_back_to_back();
      test_reset_calc();
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
